stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000: input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000: time-base strobe rate in Hz; DIV = CLK_HZ/TICK_HZ; DIV shall be an integer >= 2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_ss  input  1  start/stop button, asynchronous level, active-high.
REQ-006 btn_lr  input  1  lap/reset button, asynchronous level, active-high.
REQ-007 run  output  1  count-enable level to the time datapath.
REQ-008 tick  output  1  one-clk strobe at TICK_HZ while counting.
REQ-009 clr  output  1  one-clk synchronous clear pulse to the time datapath.
REQ-010 freeze  output  1  display-hold level; display keeps the last lap value while high.
REQ-011 lap_cnt  output  4  number of laps taken since the last clear.
REQ-012 state  output  2  current FSM state encoding.

Function
REQ-013 Each button shall pass through a 2-flop synchronizer and then a rising-edge detector; a press is one clk wide.
REQ-014 A button first sampled high at edge N shall change state at edge N+2; holding a button shall produce exactly one press.
REQ-015 FSM states: IDLE=00, RUN=01, LAP=10, PAUSE=11.
REQ-016 IDLE: run=0, freeze=0; ss press -> RUN; lr press -> stay IDLE, pulse clr.
REQ-017 RUN: run=1, freeze=0; ss press -> PAUSE; lr press -> LAP, lap_cnt increments.
REQ-018 LAP: run=1, freeze=1, counting continues; lr press -> RUN; ss press -> PAUSE with freeze released.
REQ-019 PAUSE: run=0, freeze=0; ss press -> RUN; lr press -> IDLE, pulse clr.
REQ-020 Simultaneous ss and lr presses in the same cycle: ss shall be served and lr discarded.
REQ-021 run and freeze shall be registered outputs decoded from the next state, so they change on the same edge as state.
REQ-022 clr shall be high for exactly the one cycle after the edge that takes the transition; lap_cnt and the prescaler shall clear on that same edge.
REQ-023 Prescaler: counter 0..DIV-1, advances only while run=1, wraps from DIV-1 to 0.
REQ-024 tick shall be high for the one cycle while the prescaler equals DIV-1 and run=1.
REQ-025 The prescaler shall hold its value in PAUSE, so RUN resumes with no lost or extra partial period.
REQ-026 Prescaler width = ceil(log2(DIV)); no overflow is permitted.
REQ-027 lap_cnt shall saturate at 15; further laps keep the state transitions but do not change the count.

Reset
REQ-028 While reset is high, all registers shall clear asynchronously: state=IDLE, run=0, tick=0, clr=0, freeze=0, lap_cnt=0, prescaler=0, synchronizers=0.
REQ-029 After reset deasserts, a button held high through reset shall register as one press; reset asserted mid-operation shall abort any pending press.
REQ-030 clr shall not pulse due to reset; the datapath's own reset covers that case.

Verification (CLK_HZ=10, TICK_HZ=1, so DIV=10)
REQ-031 Reset, then ss pulse 1 cycle at edge 5 -> state=RUN and run=1 after edge 7; first tick in cycle after edge 16; ticks thereafter every 10 cycles.
REQ-032 In RUN, ss press after 4 prescaler counts, wait 50 cycles, ss press again -> no tick while paused; next tick exactly 6 counted cycles after resume.
REQ-033 RUN, lr press twice -> LAP with freeze=1 and lap_cnt=1, then RUN with freeze=0 and lap_cnt=1; ticks uninterrupted throughout.
REQ-034 PAUSE, lr press -> state=IDLE, clr high exactly 1 cycle, lap_cnt=0, prescaler=0; 17 laps from RUN -> lap_cnt=15.
REQ-035 ss and lr rise on the same edge in RUN -> PAUSE with lap_cnt unchanged; btn_ss held high for 100 cycles -> exactly one transition.
REQ-036 Reset asserted asynchronously in LAP between edges -> all outputs 0 and state=00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronized start/stop and lap/reset buttons drive a 4-state FSM,
// a run-gated tick prescaler, a lap counter and one-cycle datapath clear pulses.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       run,
    output logic       tick,
    output logic       clr,
    output logic       freeze,
    output logic [3:0] lap_cnt,
    output logic [1:0] state
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_div_chk
            $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_LAP   = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    state_t          r_state;
    logic            r_run;
    logic            r_freeze;
    logic            r_clr;
    logic [3:0]      r_lap;
    logic [PW-1:0]   r_presc;
    logic [1:0]      r_ss_sync;
    logic [1:0]      r_lr_sync;
    logic            r_ss_q;
    logic            r_lr_q;

    logic            w_ss_press;
    logic            w_lr_press;
    logic            w_presc_last;

    assign w_ss_press   = r_ss_sync[1] & ~r_ss_q;
    assign w_lr_press   = r_lr_sync[1] & ~r_lr_q;
    assign w_presc_last = (r_presc == PW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_run     <= 1'b0;
            r_freeze  <= 1'b0;
            r_clr     <= 1'b0;
            r_lap     <= 4'd0;
            r_presc   <= '0;
            r_ss_sync <= 2'b00;
            r_lr_sync <= 2'b00;
            r_ss_q    <= 1'b0;
            r_lr_q    <= 1'b0;
        end else begin
            r_ss_sync <= {r_ss_sync[0], btn_ss};
            r_lr_sync <= {r_lr_sync[0], btn_lr};
            r_ss_q    <= r_ss_sync[1];
            r_lr_q    <= r_lr_sync[1];
            r_clr     <= 1'b0;

            if (r_run)
                r_presc <= w_presc_last ? '0 : r_presc + PW'(1);

            // start/stop wins: a same-cycle lap/reset press is dropped
            case (r_state)
                S_IDLE: begin
                    if (w_ss_press) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end else if (w_lr_press) begin
                        r_clr   <= 1'b1;
                        r_lap   <= 4'd0;
                        r_presc <= '0;
                    end
                end
                S_RUN: begin
                    if (w_ss_press) begin
                        r_state <= S_PAUSE;
                        r_run   <= 1'b0;
                    end else if (w_lr_press) begin
                        r_state  <= S_LAP;
                        r_freeze <= 1'b1;
                        if (r_lap != 4'd15)
                            r_lap <= r_lap + 4'd1;
                    end
                end
                S_LAP: begin
                    if (w_ss_press) begin
                        r_state  <= S_PAUSE;
                        r_run    <= 1'b0;
                        r_freeze <= 1'b0;
                    end else if (w_lr_press) begin
                        r_state  <= S_RUN;
                        r_freeze <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (w_ss_press) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end else if (w_lr_press) begin
                        r_state <= S_IDLE;
                        r_clr   <= 1'b1;
                        r_lap   <= 4'd0;
                        r_presc <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_run    <= 1'b0;
                    r_freeze <= 1'b0;
                end
            endcase
        end
    end

    assign run     = r_run;
    assign tick    = r_run & w_presc_last;
    assign clr     = r_clr;
    assign freeze  = r_freeze;
    assign lap_cnt = r_lap;
    assign state   = r_state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at DIV=10; expected values worked out by hand per edge.
module tb_stopwatch_ctrl;
    logic       clk;
    logic       reset;
    logic       btn_ss;
    logic       btn_lr;
    logic       run;
    logic       tick;
    logic       clr;
    logic       freeze;
    logic [3:0] lap_cnt;
    logic [1:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_ss  (btn_ss),
        .btn_lr  (btn_lr),
        .run     (run),
        .tick    (tick),
        .clr     (clr),
        .freeze  (freeze),
        .lap_cnt (lap_cnt),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // advance n rising edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // press sampled on the next edge; FSM reacts two edges later
    task automatic press_ss();
        btn_ss = 1'b1; step(1); btn_ss = 1'b0; step(2);
    endtask

    task automatic press_lr();
        btn_lr = 1'b1; step(1); btn_lr = 1'b0; step(2);
    endtask

    initial begin
        int nt;
        int ntr;
        logic [1:0] prev;
        reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_run", run, 0);
        chk("rst_tick", tick, 0);
        chk("rst_clr", clr, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_lap", lap_cnt, 0);

        @(posedge clk); #1 reset = 1'b0;      // edge 0
        step(4);                              // after edge 4
        btn_ss = 1'b1; step(1); btn_ss = 1'b0; // sampled at edge 5
        step(1);
        chk("e6_state", state, 0);
        chk("e6_clr", clr, 0);
        step(1);
        chk("e7_state", state, 1);
        chk("e7_run", run, 1);
        nt = 0;
        for (int i = 0; i < 8; i++) begin step(1); if (tick) nt++; end
        chk("e8_15_ticks", nt, 0);
        step(1);
        chk("e16_tick", tick, 1);
        nt = 0;
        for (int i = 0; i < 9; i++) begin step(1); if (tick) nt++; end
        chk("e17_25_ticks", nt, 0);
        step(1);
        chk("e26_tick", tick, 1);

        // pause with prescaler at 7, resume, 2 more counted cycles to tick
        step(5);
        press_ss();
        chk("pause_state", state, 3);
        chk("pause_run", run, 0);
        nt = 0;
        for (int i = 0; i < 50; i++) begin step(1); if (tick) nt++; end
        chk("pause_ticks", nt, 0);
        chk("pause_hold", state, 3);
        press_ss();
        chk("resume_state", state, 1);
        chk("resume_tick0", tick, 0);
        step(1);
        chk("resume_tick1", tick, 0);
        step(1);
        chk("resume_tick2", tick, 1);

        press_lr();
        chk("lap_state", state, 2);
        chk("lap_freeze", freeze, 1);
        chk("lap_run", run, 1);
        chk("lap_cnt1", lap_cnt, 1);
        press_lr();
        chk("unlap_state", state, 1);
        chk("unlap_freeze", freeze, 0);
        chk("unlap_cnt", lap_cnt, 1);
        step(3);
        chk("lap_tick_pre", tick, 0);
        step(1);
        chk("lap_tick", tick, 1);

        btn_ss = 1'b1; btn_lr = 1'b1; step(1);
        btn_ss = 1'b0; btn_lr = 1'b0; step(2);
        chk("both_state", state, 3);
        chk("both_lap", lap_cnt, 1);

        btn_lr = 1'b1; step(1); btn_lr = 1'b0; step(1);
        chk("clr_pre_state", state, 3);
        chk("clr_pre", clr, 0);
        step(1);
        chk("clr_state", state, 0);
        chk("clr_pulse", clr, 1);
        chk("clr_lap", lap_cnt, 0);
        step(1);
        chk("clr_post", clr, 0);

        // prescaler cleared: first tick 9 edges after the RUN edge
        press_ss();
        chk("rerun_state", state, 1);
        nt = 0;
        for (int i = 0; i < 8; i++) begin step(1); if (tick) nt++; end
        chk("rerun_ticks", nt, 0);
        step(1);
        chk("rerun_tick", tick, 1);

        for (int i = 0; i < 17; i++) begin
            press_lr();
            if (i == 14) chk("lap15", lap_cnt, 15);
            press_lr();
        end
        chk("lap_sat", lap_cnt, 15);
        chk("lap_sat_state", state, 1);

        btn_ss = 1'b1; prev = state; ntr = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (state != prev) ntr++;
            prev = state;
        end
        btn_ss = 1'b0; step(3);
        chk("hold_trans", ntr, 1);
        chk("hold_state", state, 3);

        press_ss();
        press_lr();
        chk("pre_rst_state", state, 2);
        chk("pre_rst_freeze", freeze, 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_run", run, 0);
        chk("arst_freeze", freeze, 0);
        chk("arst_tick", tick, 0);
        chk("arst_clr", clr, 0);
        chk("arst_lap", lap_cnt, 0);

        btn_ss = 1'b1;
        @(posedge clk); #4 reset = 1'b0;
        step(2);
        chk("held_e2", state, 0);
        chk("held_clr", clr, 0);
        step(1);
        chk("held_e3", state, 1);
        btn_ss = 1'b0;
        step(3);

        btn_lr = 1'b1; step(1); btn_lr = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        step(3);
        chk("abort_state", state, 0);
        chk("abort_clr", clr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
